// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out MSB-first,
// optionally repeating it back-to-back, with stall (hold) support.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic             hold,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             x_d, xv_d, busy_d, done_d, err_d;

    logic             len_ok;
    logic [LEN_W-1:0] nxt_idx;
    logic             in_bit;
    logic             pat_bit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            x       <= x_d;
            x_valid <= xv_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        x_d     = x;
        xv_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;

        len_ok  = (len != '0) && (len <= LEN_W'(WIDTH));
        // Index wraps to the top of the pattern when a pass ends, so passes abut.
        nxt_idx = (idx_q != '0) ? (idx_q - LEN_W'(1)) : (len_q - LEN_W'(1));
        in_bit  = |(pattern & (WIDTH'(1) << (len - LEN_W'(1))));
        pat_bit = |(pat_q & (WIDTH'(1) << nxt_idx));

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (len_ok) begin
                        pat_d   = pattern;
                        len_d   = len;
                        rep_d   = (reps == '0) ? REP_W'(1) : reps;
                        idx_d   = len - LEN_W'(1);
                        x_d     = in_bit;
                        xv_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (idx_q != '0) begin
                        idx_d = nxt_idx;
                        x_d   = pat_bit;
                        xv_d  = 1'b1;
                    end else if (rep_q > REP_W'(1)) begin
                        idx_d = nxt_idx;
                        rep_d = rep_q - REP_W'(1);
                        x_d   = pat_bit;
                        xv_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected bits are queued at start and
// consumed by a monitor whenever x_valid is seen.
module tb_serial_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       hold;
    logic       x, x_valid, busy, done, err;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    logic exp_q[$];
    logic [2:0] hist = '0;
    int   det_cnt = 0;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .len(len), .reps(reps), .hold(hold), .x(x), .x_valid(x_valid),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid bit must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && x_valid) begin
            logic e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got x=%b, expected no valid bit", x);
            end else begin
                e = exp_q.pop_front();
                if (x !== e) begin
                    errors++;
                    $display("FAIL stream_bit: got x=%b, expected %b", x, e);
                end
            end
            if ({hist[1:0], x} == 3'b101) det_cnt++;
            hist = {hist[1:0], x};
        end
    end

    task automatic push_exp(input logic [7:0] pat, input int ln, input int rp);
        int n = (rp == 0) ? 1 : rp;
        for (int r = 0; r < n; r++)
            for (int i = ln - 1; i >= 0; i--)
                exp_q.push_back(pat[i]);
    endtask

    // Runs one transfer; hold is driven high after observing cycles hold_lo..hold_hi.
    task automatic run_xfer(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                            input int hold_lo, input int hold_hi, input int exp_done,
                            input string name);
        bit   seen = 0;
        logic prev_x = 1'b0;
        push_exp(pat, int'(ln), int'(rp));
        pattern = pat; len = ln; reps = rp; start = 1'b1;
        for (int cyc = 1; cyc <= exp_done + 4 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
                checks++;
                if (cyc != exp_done) begin
                    errors++;
                    $display("FAIL %s_done_cycle: got %0d, expected %0d", name, cyc, exp_done);
                end
                checks++;
                if (busy !== 1'b0 || x_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done_flags: got busy=%b x_valid=%b, expected 0 0", name, busy, x_valid);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy: cycle %0d got %b, expected 1", name, cyc, busy);
                end
                if (cyc > hold_lo && cyc <= hold_hi + 1) begin
                    checks++;
                    if (x_valid !== 1'b0 || x !== prev_x) begin
                        errors++;
                        $display("FAIL %s_held: cycle %0d got x_valid=%b x=%b, expected 0 %b",
                                 name, cyc, x_valid, x, prev_x);
                    end
                end else if (x_valid !== 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_gap: cycle %0d got x_valid=%b, expected 1", name, cyc, x_valid);
                end
            end
            prev_x = x;
            hold = (cyc >= hold_lo && cyc <= hold_hi);
        end
        hold = 1'b0;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no done, expected done at cycle %0d", name, exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d bits unsent, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got done=%b after one cycle, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; hold = 1'b0;
        pattern = '0; len = '0; reps = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({x, x_valid, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 00000", {x, x_valid, busy, done, err});
        end
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1;
    endtask

    task automatic test_basic();
        det_cnt = 0; hist = '0;
        run_xfer(8'b0000_0101, 4'd3, 4'd1, 0, -1, 4, "basic");
        checks++;
        if (det_cnt != 1) begin
            errors++;
            $display("FAIL basic_detect101: got %0d hits, expected 1", det_cnt);
        end
    endtask

    task automatic test_repeat();
        run_xfer(8'b1011_0010, 4'd8, 4'd3, 0, -1, 25, "repeat3");
        run_xfer(8'b0000_0110, 4'd3, 4'd0, 0, -1, 4, "reps0");
        run_xfer(8'b1000_0000, 4'd1, 4'd4, 0, -1, 5, "len1");
    endtask

    task automatic test_hold();
        run_xfer(8'b0000_0101, 4'd3, 4'd1, 1, 2, 6, "hold");
    endtask

    task automatic test_reset_mid();
        push_exp(8'b1100_1010, 8, 2);
        pattern = 8'b1100_1010; len = 4'd8; reps = 4'd2; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        checks++;
        if ({x, x_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got x,x_valid,busy,done=%b, expected 0000", {x, x_valid, busy, done});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_nodone: got done=%b busy=%b, expected 0 0", done, busy);
            end
        end
        run_xfer(8'b0110_1001, 4'd4, 4'd2, 0, -1, 9, "after_reset");
    endtask

    task automatic test_illegal();
        logic [3:0] bad[2] = '{4'd0, 4'd9};
        foreach (bad[k]) begin
            pattern = 8'hA5; len = bad[k]; reps = 4'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_len%0d: got err=%b busy=%b x_valid=%b, expected 1 0 0",
                         bad[k], err, busy, x_valid);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_len%0d_pulse: got err=%b busy=%b, expected 0 0", bad[k], err, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit seen = 0;
        push_exp(8'b1001_1101, 8, 1);
        pattern = 8'b1001_1101; len = 4'd8; reps = 4'd1; start = 1'b1;
        for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
            @(negedge clk);
            start = (cyc >= 2);
            if (cyc >= 2) begin
                pattern = 8'hFF; len = 4'd2; reps = 4'd5;
            end
            if (done) begin
                seen = 1;
                checks++;
                if (cyc != 9) begin
                    errors++;
                    $display("FAIL ignore_done_cycle: got %0d, expected 9", cyc);
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_timeout: got no done, expected done at cycle 9");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_done: got busy=%b x_valid=%b, expected 0 0", busy, x_valid);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_leftover: got %0d bits unsent, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_hold();
        test_reset_mid();
        test_illegal();
        test_start_ignored();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1);
    end

endmodule
